rom_loader: RTL

- Sits directly downstream of the MCU SPI system block.
- Consumes its ROM byte stream (rom_loading, rom_do, rom_do_valid), packs byte pairs into 16-bit little-endian words, buffers them in a small FIFO and writes them to SDRAM over a req/ack port at sequential word addresses.
- Captures the first HDR_BYTES bytes as a header vector for core-specific mapper decode.
- Reports loaded size and a one-cycle completion pulse.

---
 rtl/rom_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// ROM byte-stream loader: packs byte pairs into little-endian words, buffers them
// in a small FIFO and writes them to SDRAM at sequential word addresses.
module rom_loader #(
  parameter int                ADDR_W     = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4,
  parameter int                HDR_BYTES  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rom_loading,
  input  logic [7:0]             rom_do,
  input  logic                   rom_do_valid,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [15:0]            mem_din,
  input  logic                   mem_ack,
  output logic [8*HDR_BYTES-1:0] hdr,
  output logic                   hdr_valid,
  output logic [23:0]            loaded_bytes,
  output logic                   load_done,
  output logic                   overflow
);

  // state | meaning
  // IDLE  | waiting for rising edge of rom_loading
  // LOAD  | accepting bytes, packing and pushing words
  // DRAIN | load window closed, emptying FIFO to memory
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t state, state_nxt;

  logic              loading_q;
  logic              rise, fall, start, flush;
  logic              accept, push_word, push, pop;
  logic              half;
  logic [7:0]        low_byte;
  logic [15:0]       push_data;
  logic [ADDR_W-1:0] next_addr;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [15:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty;

  assign rise  = rom_loading & ~loading_q;
  assign fall  = ~rom_loading & loading_q;
  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_done = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE:  if (rise) state_nxt = LOAD;
      LOAD:  if (fall) state_nxt = DRAIN;
      DRAIN: begin
        if (rise) begin
          // abandoned load: drop buffered words, no completion pulse
          state_nxt = LOAD;
          flush     = 1'b1;
        end else if (empty && !mem_req) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start     = rise && (state != LOAD);
    accept    = (state == LOAD) && rom_loading && rom_do_valid;
    push_word = (accept && half) || ((state == LOAD) && fall && half);
    push_data = accept ? {rom_do, low_byte} : {8'h00, low_byte};
    push      = push_word && !full;
    pop       = !mem_req && !empty && !flush;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= next_addr;
        fifo_data[wr_ptr] <= push_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      loading_q    <= 1'b0;
      hdr          <= '0;
      hdr_valid    <= 1'b0;
      loaded_bytes <= '0;
      overflow     <= 1'b0;
      half         <= 1'b0;
      low_byte     <= '0;
      next_addr    <= BASE_ADDR;
      mem_req      <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_din      <= '0;
    end else begin
      loading_q <= rom_loading;
      if (start) begin
        hdr          <= '0;
        hdr_valid    <= 1'b0;
        loaded_bytes <= '0;
        overflow     <= 1'b0;
        half         <= 1'b0;
        next_addr    <= BASE_ADDR;
      end else begin
        if (accept) begin
          for (int i = 0; i < HDR_BYTES; i++)
            if (loaded_bytes == 24'(i)) hdr[8*i +: 8] <= rom_do;
          if (loaded_bytes == 24'(HDR_BYTES-1)) hdr_valid <= 1'b1;
          if (loaded_bytes != 24'hFFFFFF) loaded_bytes <= loaded_bytes + 1'b1;
          if (!half) low_byte <= rom_do;
          half <= ~half;
        end
        if ((state == LOAD) && fall) begin
          hdr_valid <= 1'b1;
          half      <= 1'b0;
        end
        // address advances on dropped words too so later data stays aligned
        if (push_word) begin
          next_addr <= next_addr + 1'b1;
          if (full) overflow <= 1'b1;
        end
      end

      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end else if (pop) begin
        mem_req  <= 1'b1;
        mem_addr <= fifo_addr[rd_ptr];
        mem_din  <= fifo_data[rd_ptr];
      end
    end
  end

endmodule
